exec_result_buf: RTL and testbench
==================================

# exec_result_buf

Result buffer sitting directly downstream of a single-cycle execution unit (e.g. the subtract unit), between that unit's outputs and the common data bus (CDB) writeback arbiter. It captures each completed result (ROB uid, 16-bit value, 18-bit destination location) in an in-order FIFO and presents results to the CDB with a valid/ready handshake. It also returns a registered-state `accept_ok` to the issue stage so that no result is issued into a full buffer.

## Interface
Parameters:
- `DEPTH`, 4, number of result entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `has_incoming`  in  1  result valid from the execution unit this cycle.
- `in_uid`  in  `ROB_QUEUE_BITS`  ROB uid of the incoming result.
- `in_val`  in  16  result value.
- `in_loc`  in  18  destination location; `[17:16]==2'b00` means register, `[15:0]` is the register address.
- `accept_ok`  out  1  the issue stage may dispatch to the execution unit this cycle.
- `cdb_valid`  out  1  head result is presented to the CDB.
- `cdb_ready`  in  1  the CDB arbiter takes the presented result this cycle.
- `cdb_uid`  out  `ROB_QUEUE_BITS`  presented uid.
- `cdb_val`  out  16  presented value.
- `cdb_loc`  out  18  presented location.
- `count`  out  `$clog2(DEPTH+1)`  occupied entries.
- `overflow`  out  1  sticky error: a result arrived while the buffer was full.

## Operation
- Circular FIFO with head/tail pointers wrapping modulo `DEPTH`. `count` is stored as a register, so full and empty are unambiguous.
- **Push:** `has_incoming && count<DEPTH`. Writes `{in_uid,in_val,in_loc}` at the tail, then increments the tail.
- **Pop:** `cdb_valid && cdb_ready`. Increments the head.
- **Simultaneous push and pop:** `count` is unchanged, both pointers advance. At `count==1`, the entry being popped is the old head, and the new entry becomes the head next cycle.
- **Push while full** (`count==DEPTH`): the push is dropped even if a pop occurs in the same cycle. `overflow` is set to 1 and stays 1 until reset. This is an upstream protocol violation.
- `accept_ok = rst_n && (count<DEPTH)`. It is a function of registered state only, with no combinational path from `cdb_ready`.
- `cdb_valid = (count!=0)` (see Configuration for bypass). When `cdb_valid==0`, `cdb_uid`, `cdb_val` and `cdb_loc` are all 0.
- Payload passes through unmodified; the block performs no arithmetic on `val`/`loc`.
- Results leave in arrival order.
- **Reset** (any cycle, including mid-stream): pointers, `count` and `overflow` are cleared; buffered entries are discarded. Memory contents need not be cleared.

## Timing
- **Reset values:** `count=0`, `overflow=0`, `cdb_valid=0`, `cdb_*=0`, and `accept_ok=0` while `rst_n` is low. `accept_ok` rises in the first cycle after reset is released.
- **Latency without bypass:** a result pushed in cycle N is presented in cycle N+1 at the earliest.
- **Throughput:** one push and one pop per cycle, sustained.
- **Handshake:** once `cdb_valid` is high, the presented payload is held stable until it is popped. Stability across reset is not guaranteed.
- **`accept_ok`:** goes low in the cycle after the push that fills the buffer. It returns high in the cycle after the pop that frees an entry.

## Configuration
- Macro `EXEC_RESULT_BUF_BYPASS_EN`.
- **Defined:** when `count==0 && has_incoming && cdb_ready`, the input is presented combinationally on `cdb_*` with `cdb_valid=1`, and nothing is stored. Latency is 0 and `count` stays 0. If `cdb_ready==0`, the result is stored normally.
- **Undefined:** there is no input-to-output combinational path, and latency is always ≥ 1.

## Structure
- **Shared package `exec_pkg`:**
  - `typedef struct packed { logic [`ROB_QUEUE_BITS-1:0] uid; logic [15:0] val; logic [17:0] loc; } exec_result_t;`
  - `localparam logic [1:0] LOC_REG = 2'b00;`
  - Other execution units and the CDB arbiter reuse both.
- **Sub-module `exec_result_mem`:** a `DEPTH`×`exec_result_t` storage array with one synchronous write port and one asynchronous read port. The pointer, count and flag logic stays in `exec_result_buf`.

## Test plan
- **Basic pass:** reset, then push uid=3, val=16'h0005, loc=18'h0000A with `cdb_ready=1` → cdb shows uid 3 / 5 / 0000A in the next cycle (same cycle with bypass); `count` returns to 0.
- **Fill and backpressure:** `DEPTH=4`, `cdb_ready=0`, push uids 0–3 in four consecutive cycles → `count=4`, `accept_ok=0` from cycle 5, head remains uid 0 and stable.
- **Drain order:** from the full state, hold `cdb_ready=1` for 4 cycles → uids 0,1,2,3 are popped in order, `cdb_valid` drops after the fourth, `accept_ok` goes high after the first pop.
- **Concurrent push/pop:** at `count=2`, push uid 7 while popping → `count` stays 2, and uid 7 appears after the older entry.
- **Overflow:** at `count=4`, push uid 9 with `cdb_ready=1` → uid 9 is dropped, `overflow=1` is sticky, and the next three pops do not contain 9.
- **Reset mid-stream:** at `count=3`, drive `rst_n=0` for one cycle → `count=0`, `cdb_valid=0`, `overflow=0`; a subsequent push behaves as in the basic pass.

Source files
------------

// File: rtl/exec_pkg.sv
// ============================================================================
// Module  : exec_pkg
// Brief   : Shared execution-result types, reused by the execution units,
//           their result buffers and the CDB writeback arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 4
`endif

package exec_pkg;

   // One completed result: ROB uid, value and destination location
   typedef struct packed {
      logic [`ROB_QUEUE_BITS-1:0] uid;
      logic [15:0]                val;
      logic [17:0]                loc;
   } exec_result_t;

   // loc[17:16] tag meaning "architectural register"; loc[15:0] is its address
   localparam logic [1:0] LOC_REG = 2'b00;

endpackage

`default_nettype wire

// File: rtl/exec_result_mem.sv
// ============================================================================
// Module  : exec_result_mem
// Brief   : DEPTH x exec_result_t storage array with one synchronous write
//           port and one asynchronous read port. The contents are not reset;
//           validity is tracked by the owning buffer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_result_mem
   import exec_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  exec_result_t  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output exec_result_t  o_rdata
);

   exec_result_t r_mem [DEPTH];

   // Write the incoming result into its slot on the clock edge
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/exec_result_buf.sv
// ============================================================================
// Module  : exec_result_buf
// Brief   : In-order result FIFO between a single-cycle execution unit and
//           the CDB writeback arbiter, with valid/ready output handshake,
//           registered-state accept_ok back-pressure and a sticky overflow
//           flag.
// Config  : EXEC_RESULT_BUF_BYPASS_EN - when defined, an incoming result is
//           forwarded combinationally to the CDB if the buffer is empty and
//           the CDB is ready; otherwise it is always stored first.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_result_buf
   import exec_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          has_incoming,
   input  logic [`ROB_QUEUE_BITS-1:0]    in_uid,
   input  logic [15:0]                   in_val,
   input  logic [17:0]                   in_loc,
   output logic                          accept_ok,
   output logic                          cdb_valid,
   input  logic                          cdb_ready,
   output logic [`ROB_QUEUE_BITS-1:0]    cdb_uid,
   output logic [15:0]                   cdb_val,
   output logic [17:0]                   cdb_loc,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          overflow
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0] c_ZERO  = '0;

   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   logic          w_full;
   logic          w_empty;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   exec_result_t  w_in;
   exec_result_t  w_head;
   exec_result_t  w_out;

   assign w_in    = '{uid: in_uid, val: in_val, loc: in_loc};
   assign w_full  = (r_count == c_DEPTH);
   assign w_empty = (r_count == c_ZERO);

`ifdef EXEC_RESULT_BUF_BYPASS_EN
   assign w_bypass = w_empty && has_incoming && cdb_ready;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed result never touches storage; a push while full is dropped
   assign w_push = has_incoming && !w_full && !w_bypass;
   assign w_pop  = !w_empty && cdb_ready;

   exec_result_mem #(
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_tail),
      .i_wdata (w_in),
      .i_raddr (r_head),
      .o_rdata (w_head)
   );

   // Pointer, occupancy and sticky-error state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + 1'b1;
         end
         if (w_pop) begin
            r_head <= r_head + 1'b1;
         end
         r_count <= r_count + {{(CW-1){1'b0}}, w_push}
                            - {{(CW-1){1'b0}}, w_pop};
         if (has_incoming && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Select head entry or bypassed input and zero the payload when idle
   always_comb begin
      w_out = '0;
      if (w_bypass) begin
         w_out = w_in;
      end else if (!w_empty) begin
         w_out = w_head;
      end
   end

   assign cdb_valid = !w_empty || w_bypass;
   assign cdb_uid   = w_out.uid;
   assign cdb_val   = w_out.val;
   assign cdb_loc   = w_out.loc;
   assign accept_ok = rst_n && !w_full;
   assign count     = r_count;
   assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_exec_result_buf.sv
// ============================================================================
// Module  : tb_exec_result_buf
// Brief   : Scoreboard bench for exec_result_buf (DEPTH=4). The stimulus
//           process queues the expected results; a monitor compares every
//           handshake on the CDB side against the queue head.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 4
`endif

module tb_exec_result_buf;

   localparam int DEPTH = 4;
   localparam int UW    = `ROB_QUEUE_BITS;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst_n;
   logic          has_incoming;
   logic [UW-1:0] in_uid;
   logic [15:0]   in_val;
   logic [17:0]   in_loc;
   logic          accept_ok;
   logic          cdb_valid;
   logic          cdb_ready;
   logic [UW-1:0] cdb_uid;
   logic [15:0]   cdb_val;
   logic [17:0]   cdb_loc;
   logic [CW-1:0] count;
   logic          overflow;

   logic [UW+33:0] exp_q [$];
   int n_pass  = 0;
   int n_total = 0;

   exec_result_buf #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .has_incoming (has_incoming),
      .in_uid       (in_uid),
      .in_val       (in_val),
      .in_loc       (in_loc),
      .accept_ok    (accept_ok),
      .cdb_valid    (cdb_valid),
      .cdb_ready    (cdb_ready),
      .cdb_uid      (cdb_uid),
      .cdb_val      (cdb_val),
      .cdb_loc      (cdb_loc),
      .count        (count),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every accepted CDB transfer must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && cdb_valid && cdb_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pop", {30'd0, cdb_uid, cdb_val, cdb_loc}, 64'hDEAD);
         end else begin
            chk("pop_payload", {30'd0, cdb_uid, cdb_val, cdb_loc}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [UW-1:0] u,
                        input logic [15:0] d, input logic [17:0] l, input logic expect_store);
      has_incoming = v;
      in_uid       = u;
      in_val       = d;
      in_loc       = l;
      if (v && expect_store) exp_q.push_back({u, d, l});
   endtask

   initial begin
      rst_n = 1'b0; cdb_ready = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0);
      step(); step();
      chk("rst_count",     64'(count), 64'd0);
      chk("rst_overflow",  64'(overflow), 64'd0);
      chk("rst_valid",     64'(cdb_valid), 64'd0);
      chk("rst_accept",    64'(accept_ok), 64'd0);
      chk("rst_payload",   {30'd0, cdb_uid, cdb_val, cdb_loc}, 64'd0);
      rst_n = 1'b1;
      step();
      chk("accept_after_rst", 64'(accept_ok), 64'd1);

      // Basic pass
      cdb_ready = 1'b1;
      drive(1'b1, UW'(3), 16'h0005, 18'h0000A, 1'b1);
      step();
      drive(1'b0, '0, '0, '0, 1'b0);
`ifndef EXEC_RESULT_BUF_BYPASS_EN
      chk("basic_latency_valid", 64'(cdb_valid), 64'd1);
      chk("basic_latency_uid",   64'(cdb_uid), 64'd3);
`endif
      step();
      chk("basic_count", 64'(count), 64'd0);

      // Fill with back-pressure
      cdb_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, UW'(i), 16'h0100 + 16'(i), 18'h00010 + 18'(i), 1'b1);
         step();
         if (i == 2) chk("accept_at_3", 64'(accept_ok), 64'd1);
      end
      drive(1'b0, '0, '0, '0, 1'b0);
      chk("full_count",  64'(count), 64'd4);
      chk("full_accept", 64'(accept_ok), 64'd0);
      chk("full_head",   {30'd0, cdb_uid, cdb_val, cdb_loc}, {30'd0, UW'(0), 16'h0100, 18'h00010});
      step(); step();
      chk("full_head_stable", {30'd0, cdb_uid, cdb_val, cdb_loc}, {30'd0, UW'(0), 16'h0100, 18'h00010});

      // Drain in order
      cdb_ready = 1'b1;
      step();
      chk("drain_accept", 64'(accept_ok), 64'd1);
      chk("drain_count",  64'(count), 64'd3);
      step(); step(); step();
      chk("drain_valid",   64'(cdb_valid), 64'd0);
      chk("drain_count0",  64'(count), 64'd0);
      chk("idle_payload",  {30'd0, cdb_uid, cdb_val, cdb_loc}, 64'd0);

      // Concurrent push and pop at count=2
      cdb_ready = 1'b0;
      drive(1'b1, UW'(4), 16'h0044, 18'h10004, 1'b1); step();
      drive(1'b1, UW'(5), 16'h0055, 18'h20005, 1'b1); step();
      chk("conc_count_pre", 64'(count), 64'd2);
      cdb_ready = 1'b1;
      drive(1'b1, UW'(7), 16'h0077, 18'h30007, 1'b1); step();
      drive(1'b0, '0, '0, '0, 1'b0);
      chk("conc_count", 64'(count), 64'd2);
      step(); step();
      chk("conc_drained", 64'(count), 64'd0);

      // Overflow: push while full is dropped even with a pop
      cdb_ready = 1'b0;
      drive(1'b1, UW'(8),  16'h0808, 18'h00008, 1'b1); step();
      drive(1'b1, UW'(10), 16'h0A0A, 18'h0000A, 1'b1); step();
      drive(1'b1, UW'(11), 16'h0B0B, 18'h0000B, 1'b1); step();
      drive(1'b1, UW'(12), 16'h0C0C, 18'h0000C, 1'b1); step();
      chk("ovf_pre", 64'(overflow), 64'd0);
      cdb_ready = 1'b1;
      drive(1'b1, UW'(9), 16'h0909, 18'h00009, 1'b0); step();
      drive(1'b0, '0, '0, '0, 1'b0);
      chk("ovf_set",   64'(overflow), 64'd1);
      chk("ovf_count", 64'(count), 64'd3);
      step(); step(); step();
      chk("ovf_sticky",  64'(overflow), 64'd1);
      chk("ovf_drained", 64'(cdb_valid), 64'd0);

      // Reset mid-stream at count=3
      cdb_ready = 1'b0;
      drive(1'b1, UW'(1), 16'h1111, 18'h00001, 1'b1); step();
      drive(1'b1, UW'(2), 16'h2222, 18'h00002, 1'b1); step();
      drive(1'b1, UW'(3), 16'h3333, 18'h00003, 1'b1); step();
      drive(1'b0, '0, '0, '0, 1'b0);
      chk("mid_count3", 64'(count), 64'd3);
      rst_n = 1'b0;
      exp_q.delete();
      step();
      rst_n = 1'b1;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(cdb_valid), 64'd0);
      chk("mid_rst_ovf",   64'(overflow), 64'd0);

      // Basic pass again after reset
      cdb_ready = 1'b1;
      drive(1'b1, UW'(3), 16'h0005, 18'h0000A, 1'b1);
      step();
      drive(1'b0, '0, '0, '0, 1'b0);
      step();
      chk("post_rst_count", 64'(count), 64'd0);
      step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
